// File: rtl/telemetry_frame_tx.sv
// telemetry_frame_tx
// Snapshots NCH channels of CH_W bits and streams them to a byte-wide UART as
// uppercase hex ASCII: "<ch0> <ch1> ... <chN-1> " then CR LF.
// A frame starts on frame_req or on the free-running period counter wrapping
// (PERIOD = 0 turns the auto-trigger off). Triggers seen mid-frame are dropped
// and flagged in the sticky overrun bit.
// Optional build macro TLM_CHECKSUM_EN: adds two hex digits of the XOR of all
// preceding frame bytes just before CR LF.
module telemetry_frame_tx #(
    parameter int NCH    = 4,
    parameter int CH_W   = 12,
    parameter int PERIOD = 100000
) (
    input  logic                CLK_10MHZ,
    input  logic                rst_n,
    input  logic [NCH*CH_W-1:0] ch_data,
    input  logic                frame_req,
    input  logic                tx_busy,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    output logic                frame_busy,
    output logic                frame_done,
    output logic                overrun,
    input  logic                overrun_clr
);

    localparam int DIG      = CH_W / 4;          // hex digits per channel
    localparam int DATA_LEN = NCH * (DIG + 1);   // digits plus trailing space per channel
`ifdef TLM_CHECKSUM_EN
    localparam int TAIL_LEN = 4;                 // two checksum digits, CR, LF
`else
    localparam int TAIL_LEN = 2;                 // CR, LF
`endif
    localparam int FRAME_LEN = DATA_LEN + TAIL_LEN;
    localparam int IDX_W     = $clog2(FRAME_LEN + 1);
    localparam int PC_W      = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_SEND      = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;

    logic [2:0]          r_state;
    logic [NCH*CH_W-1:0] r_snap;
    logic [IDX_W-1:0]    r_idx;      // byte position within the frame
    logic [3:0]          r_ch;       // channel being emitted
    logic [3:0]          r_pos;      // digit within channel, DIG = the space
    logic [PC_W-1:0]     r_per_cnt;
    logic                r_tx_start;
    logic [7:0]          r_tx_data;
    logic                r_frame_busy;
    logic                r_frame_done;
    logic                r_overrun;
`ifdef TLM_CHECKSUM_EN
    logic [7:0]          r_csum;
`endif

    logic                w_auto;
    logic                w_trig;
    logic                w_in_data;
    logic                w_last;
    logic [3:0]          w_nib;
    logic [IDX_W-1:0]    w_tail;
    logic [7:0]          w_byte;

    // Nibble to uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            hex_ascii = {4'h3, nib};
        end else begin
            hex_ascii = 8'h37 + {4'h0, nib};
        end
    endfunction

    // Trigger sources: host request or period counter about to wrap; both in one cycle count once.
    always_comb begin
        w_auto = 1'b0;
        if (PERIOD > 0) begin
            w_auto = (r_per_cnt == PC_W'(PERIOD - 1));
        end else begin
            w_auto = 1'b0;
        end
        w_trig = frame_req | w_auto;
    end

    // Free-running period counter, wraps at PERIOD-1 regardless of frame activity.
    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_per_cnt <= {PC_W{1'b0}};
        end else if (PERIOD == 0) begin
            r_per_cnt <= {PC_W{1'b0}};
        end else if (w_auto) begin
            r_per_cnt <= {PC_W{1'b0}};
        end else begin
            r_per_cnt <= r_per_cnt + PC_W'(1);
        end
    end

    // Select the next frame byte from the snapshot, position counters and checksum.
    always_comb begin
        w_in_data = (r_idx < IDX_W'(DATA_LEN));
        w_last    = (r_idx == IDX_W'(FRAME_LEN - 1));
        w_tail    = r_idx - IDX_W'(DATA_LEN);
        w_nib     = 4'h0;
        for (int c = 0; c < NCH; c++) begin
            for (int d = 0; d < DIG; d++) begin
                w_nib = w_nib | ({4{(r_ch == 4'(c)) && (r_pos == 4'(d))}}
                                 & r_snap[c*CH_W + (DIG-1-d)*4 +: 4]);
            end
        end
        w_byte = 8'h00;
        if (w_in_data) begin
            if (r_pos == 4'(DIG)) begin
                w_byte = 8'h20;
            end else begin
                w_byte = hex_ascii(w_nib);
            end
        end else begin
            case (w_tail)
`ifdef TLM_CHECKSUM_EN
                IDX_W'(0): w_byte = hex_ascii(r_csum[7:4]);
                IDX_W'(1): w_byte = hex_ascii(r_csum[3:0]);
                IDX_W'(2): w_byte = 8'h0D;
`else
                IDX_W'(0): w_byte = 8'h0D;
`endif
                default:   w_byte = 8'h0A;
            endcase
        end
    end

    // Frame sequencer: one UART handshake per byte, snapshot taken on the accepted trigger.
    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_snap       <= {(NCH*CH_W){1'b0}};
            r_idx        <= {IDX_W{1'b0}};
            r_ch         <= 4'd0;
            r_pos        <= 4'd0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_frame_busy <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef TLM_CHECKSUM_EN
            r_csum       <= 8'h00;
`endif
        end else begin
            r_tx_start   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_trig) begin
                        r_snap       <= ch_data;
                        r_idx        <= {IDX_W{1'b0}};
                        r_ch         <= 4'd0;
                        r_pos        <= 4'd0;
                        r_frame_busy <= 1'b1;
`ifdef TLM_CHECKSUM_EN
                        r_csum       <= 8'h00;
`endif
                        r_state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_tx_data <= w_byte;
`ifdef TLM_CHECKSUM_EN
                    if (w_in_data) begin
                        r_csum <= r_csum ^ w_byte;
                    end
`endif
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_state    <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (w_last) begin
                            r_frame_busy <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                            if (w_in_data) begin
                                if (r_pos == 4'(DIG)) begin
                                    r_pos <= 4'd0;
                                    r_ch  <= r_ch + 4'd1;
                                end else begin
                                    r_pos <= r_pos + 4'd1;
                                end
                            end
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    r_frame_busy <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun: a trigger while busy sets it; setting wins over a same-cycle clear.
    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_trig && r_frame_busy) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_overrun;
        end
    end

    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign frame_busy = r_frame_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_telemetry_frame_tx.sv
// Bench for telemetry_frame_tx: dut_a (manual trigger) runs table, snapshot,
// overrun, reset and random tests; dut_b (PERIOD=50) checks auto-triggering.
`timescale 1ns/1ps
module tb_telemetry_frame_tx;
    localparam int NCH = 2;
    localparam int CH_W = 12;
`ifdef TLM_CHECKSUM_EN
    localparam int FLEN = 12;
`else
    localparam int FLEN = 10;
`endif

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic rst_n, frame_req, overrun_clr;
    logic tx_busy = 1'b0;
    logic [23:0] ch_data;
    logic tx_start, frame_busy, frame_done, overrun;
    logic [7:0] tx_data;

    logic rst_nb;
    logic req_b = 1'b0;
    logic clr_b = 1'b0;
    logic busy_b = 1'b0;
    logic [23:0] ch_b = 24'h123456;
    logic start_b, fbusy_b, fdone_b, ovr_b;
    logic [7:0] data_b;

    telemetry_frame_tx #(.NCH(NCH), .CH_W(CH_W), .PERIOD(0)) dut_a (
        .CLK_10MHZ(clk), .rst_n(rst_n), .ch_data(ch_data), .frame_req(frame_req),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .frame_busy(frame_busy), .frame_done(frame_done), .overrun(overrun),
        .overrun_clr(overrun_clr));

    telemetry_frame_tx #(.NCH(NCH), .CH_W(CH_W), .PERIOD(50)) dut_b (
        .CLK_10MHZ(clk), .rst_n(rst_nb), .ch_data(ch_b), .frame_req(req_b),
        .tx_busy(busy_b), .tx_start(start_b), .tx_data(data_b),
        .frame_busy(fbusy_b), .frame_done(fdone_b), .overrun(ovr_b),
        .overrun_clr(clr_b));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame bytes derived from the text format.
    function automatic logic [7:0] hexc(input int d);
        return (d < 10) ? 8'(48 + d) : 8'(55 + d);
    endfunction

    function automatic logic [7:0] data_byte(input logic [23:0] ch, input int i);
        int c = i / 4;
        int p = i % 4;
        int v = (int'(ch) / (1 << (12 * c))) % 4096;
        if (p == 3) return 8'h20;
        return hexc((v / (1 << (4 * (2 - p)))) % 16);
    endfunction

    function automatic logic [7:0] model_byte(input logic [23:0] ch, input int i);
        int x = 0;
        int t = i - 8;
        if (i < 8) return data_byte(ch, i);
        for (int j = 0; j < 8; j++) x = x ^ int'(data_byte(ch, j));
`ifdef TLM_CHECKSUM_EN
        if (t == 0) return hexc(x / 16);
        if (t == 1) return hexc(x % 16);
        if (t == 2) return 8'h0D;
        return 8'h0A;
`else
        if (t == 0) return 8'h0D;
        return 8'h0A;
`endif
    endfunction

    // UART models: capture on tx_start, hold busy for a (random) number of cycles.
    int blen_a = 0;
    int blen_b = 1;
    int bcnt_a = 0;
    int bcnt_b = 0;
    int starts_a = 0;
    logic [7:0] held_a, held_b;
    logic [7:0] cap_a[$];
    logic [7:0] cap_b[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            tx_busy = 1'b0;
            bcnt_a = 0;
        end else if (bcnt_a > 0) begin
            chk("A_tx_data_stable", tx_data, held_a);
            chk("A_no_start_while_busy", tx_start, 1'b0);
            bcnt_a--;
            if (bcnt_a == 0) tx_busy = 1'b0;
        end else if (tx_start) begin
            cap_a.push_back(tx_data);
            held_a = tx_data;
            starts_a++;
            tx_busy = 1'b1;
            bcnt_a = (blen_a == 0) ? int'($urandom_range(4, 1)) : blen_a;
        end
    end

    always @(negedge clk) begin
        if (!rst_nb) begin
            busy_b = 1'b0;
            bcnt_b = 0;
        end else if (bcnt_b > 0) begin
            chk("B_tx_data_stable", data_b, held_b);
            bcnt_b--;
            if (bcnt_b == 0) busy_b = 1'b0;
        end else if (start_b) begin
            cap_b.push_back(data_b);
            held_b = data_b;
            busy_b = 1'b1;
            bcnt_b = blen_b;
        end
    end

    // dut_b frame monitor: start timestamps and content check on each frame_done.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int starts_b[$];
    int frames_b = 0;
    logic prev_fb_b = 1'b0;
    always @(negedge clk) begin
        if (!rst_nb) begin
            prev_fb_b = 1'b0;
        end else begin
            if (fbusy_b && !prev_fb_b) begin
                starts_b.push_back(cyc);
                cap_b.delete();
            end
            if (fdone_b) begin
                chk("B_frame_len", cap_b.size(), FLEN);
                for (int i = 0; i < FLEN && i < cap_b.size(); i++)
                    chk("B_frame_byte", cap_b[i], model_byte(ch_b, i));
                frames_b++;
            end
            prev_fb_b = fbusy_b;
        end
    end

    task automatic wait_cap(input int n);
        int k = 0;
        while (cap_a.size() < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (cap_a.size() < n) chk("A_byte_timeout", cap_a.size(), n);
    endtask

    task automatic wait_done_a();
        int k = 0;
        logic drop = 1'b0;
        while (!frame_done && k < 3000) begin
            if (!frame_busy) drop = 1'b1;
            @(negedge clk);
            k++;
        end
        chk("A_frame_done_seen", frame_done, 1'b1);
        chk("A_busy_held", drop, 1'b0);
        @(negedge clk);
        chk("A_done_one_cycle", frame_done, 1'b0);
        chk("A_idle_after_done", frame_busy, 1'b0);
    endtask

    task automatic trigger_a(input logic [23:0] ch);
        ch_data = ch;
        cap_a.delete();
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        chk("A_busy_after_trigger", frame_busy, 1'b1);
    endtask

    task automatic check_model_a(input string nm, input logic [23:0] ch);
        chk({nm, "_len"}, cap_a.size(), FLEN);
        for (int i = 0; i < FLEN && i < cap_a.size(); i++)
            chk({nm, "_byte"}, cap_a[i], model_byte(ch, i));
    endtask

    typedef struct {
        logic [23:0] ch;
        logic [63:0] body;
        logic [7:0]  csum;
    } vec_t;
    vec_t tbl[4];

    initial begin
        #(100 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] tmp;
        logic [7:0] expb[12];
        logic [23:0] orig;
        int s0, k;

        tbl[0] = '{ch: 24'h05FABC, body: 64'h4142432030354620, csum: 8'h03};
        tbl[1] = '{ch: 24'h000000, body: 64'h3030302030303020, csum: 8'h00};
        tbl[2] = '{ch: 24'hFFF123, body: 64'h3132332046464620, csum: 8'h76};
        tbl[3] = '{ch: 24'h9A07E1, body: 64'h3745312039413020, csum: 8'h0B};

        rst_n = 1'b0; rst_nb = 1'b0; frame_req = 1'b0; overrun_clr = 1'b0; ch_data = 24'h0;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_frame_busy", frame_busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven frames with hand-derived bytes and checksums.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 8; j++) begin
                tmp = tbl[i].body >> (56 - 8 * j);
                expb[j] = tmp[7:0];
            end
`ifdef TLM_CHECKSUM_EN
            expb[8] = hexc(int'(tbl[i].csum[7:4]));
            expb[9] = hexc(int'(tbl[i].csum[3:0]));
            expb[10] = 8'h0D; expb[11] = 8'h0A;
`else
            expb[8] = 8'h0D; expb[9] = 8'h0A;
`endif
            trigger_a(tbl[i].ch);
            wait_done_a();
            chk("tbl_len", cap_a.size(), FLEN);
            for (int j = 0; j < FLEN && j < cap_a.size(); j++)
                chk("tbl_byte", cap_a[j], expb[j]);
        end

        // Snapshot: input change mid-frame must not leak into the frame.
        orig = 24'h321654;
        trigger_a(orig);
        wait_cap(3);
        ch_data = 24'hFFFFFF;
        wait_done_a();
        check_model_a("snap_old", orig);
        trigger_a(24'hFFFFFF);
        wait_done_a();
        check_model_a("snap_new", 24'hFFFFFF);

        // Overrun: dropped trigger, set-over-clear priority, clear.
        orig = 24'hC0DE42;
        trigger_a(orig);
        wait_cap(2);
        chk("ovr_before", overrun, 1'b0);
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        chk("ovr_set", overrun, 1'b1);
        frame_req = 1'b1; overrun_clr = 1'b1;
        @(negedge clk);
        frame_req = 1'b0; overrun_clr = 1'b0;
        chk("ovr_set_beats_clr", overrun, 1'b1);
        wait_done_a();
        check_model_a("ovr_frame", orig);
        repeat (30) @(negedge clk);
        chk("ovr_no_extra_frame", cap_a.size(), FLEN);
        chk("ovr_sticky", overrun, 1'b1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("ovr_cleared", overrun, 1'b0);

        // Reset during byte 3: outputs to reset values, no restart without trigger.
        trigger_a(24'h0F0A5A);
        wait_cap(1);
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        wait_cap(3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_start", tx_start, 1'b0);
        chk("mid_rst_tx_data", tx_data, 8'h00);
        chk("mid_rst_frame_busy", frame_busy, 1'b0);
        chk("mid_rst_frame_done", frame_done, 1'b0);
        chk("mid_rst_overrun", overrun, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s0 = starts_a;
        repeat (40) @(negedge clk);
        chk("no_start_after_reset", starts_a, s0);
        chk("idle_after_reset", frame_busy, 1'b0);

        // Randomized frames against the model.
        for (int r = 0; r < 6; r++) begin
            orig = 24'($urandom);
            trigger_a(orig);
            wait_done_a();
            check_model_a("rand", orig);
        end

        // Auto-trigger, fast UART: frames every 50 clocks, no overrun.
        rst_nb = 1'b1;
        k = 0;
        while (frames_b < 4 && k < 1500) begin
            @(negedge clk);
            k++;
        end
        chk("B_fast_frames", (frames_b >= 4) ? 1 : 0, 1);
        for (int i = 1; i < starts_b.size(); i++)
            chk("B_period_50", starts_b[i] - starts_b[i-1], 50);
        chk("B_fast_no_overrun", ovr_b, 1'b0);

        // Slow UART: frames outlast the period, so overrun sets and starts skip slots.
        blen_b = 6;
        k = 0;
        while (!ovr_b && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("B_slow_overrun", ovr_b, 1'b1);
        s0 = starts_b.size();
        k = 0;
        while (starts_b.size() < s0 + 2 && k < 1500) begin
            @(negedge clk);
            k++;
        end
        chk("B_slow_starts", (starts_b.size() >= s0 + 2) ? 1 : 0, 1);
        for (int i = s0; i < starts_b.size(); i++) begin
            chk("B_slow_period_mult", (starts_b[i] - starts_b[i-1]) % 50, 0);
            chk("B_slow_period_min", (starts_b[i] - starts_b[i-1] >= 100) ? 1 : 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
